data_bus_bridge: RTL and testbench
==================================

# data_bus_bridge

Bridges the core's single-cycle data-RAM port (ce/we/sel/addr/data, as driven by the MEM stage) to a multi-cycle request/acknowledge data bus. It sits directly downstream of the core's `ram_*` outputs. It holds the MEM stage through a combinational stall request until the bus acknowledges. It then presents the captured read word for exactly one cycle so the pipeline can advance.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles in BUSY before forcing completion; range 1..1023.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ram_ce_i`  in  1  core access request.
- `ram_we_i`  in  1  1 = write, 0 = read.
- `ram_sel_i`  in  4  byte-lane enables.
- `ram_addr_i`  in  32  byte address.
- `ram_data_i`  in  32  write data from the core.
- `ram_data_o`  out  32  read data to the core.
- `stallreq_o`  out  1  combinational stall request to the pipeline controller.
- `bus_req_o`  out  1  bus request, registered.
- `bus_we_o`  out  1  latched write flag.
- `bus_sel_o`  out  4  latched byte enables.
- `bus_addr_o`  out  32  latched address, word-aligned as {addr[31:2],2'b00}.
- `bus_wdata_o`  out  32  latched write data.
- `bus_ack_i`  in  1  bus acknowledge; single-cycle pulse.
- `bus_rdata_i`  in  32  read data, valid when `bus_ack_i` = 1.
- `err_o`  out  1  sticky timeout flag.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- **IDLE:**
  - If `ram_ce_i` = 1, `stallreq_o` = 1 in the same cycle (combinational).
  - On the clock edge, latch we/sel/addr/wdata into the bus registers, set `bus_req_o` = 1, clear the timeout counter and go to BUSY.
  - If `ram_ce_i` = 0, nothing happens and `stallreq_o` = 0.
- **BUSY:**
  - `stallreq_o` = 1 and `bus_req_o` = 1.
  - The timeout counter increments each cycle.
  - If `bus_ack_i` = 1, capture `bus_rdata_i` into the read register (or 0 when `bus_we_o` = 1), drop `bus_req_o` and go to DONE.
  - Else, if the counter reaches `TIMEOUT_CYCLES`, load 0 into the read register, drop `bus_req_o`, set `err_o` and go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and `err_o` is not set.
- **DONE:**
  - `stallreq_o` = 0 and `ram_data_o` = the read register.
  - Unconditionally return to IDLE on the next edge.
  - DONE ignores `ram_ce_i`, so a back-to-back access is picked up in the following IDLE cycle.
- `ram_data_o` = the read register in DONE, and 0 in every other state.
- Bus latches are loaded only on the IDLE→BUSY transition. Changes on the core inputs during BUSY/DONE have no effect, and `ram_ce_i` dropping during BUSY does not abort the transaction.
- `bus_ack_i` in IDLE or DONE is spurious and ignored, with no state or data change.
- `err_o` stays 1 until `rst`.

## Timing
- **Reset values:** `bus_req_o`, `bus_we_o` and `err_o` = 0; `bus_sel_o` = 4'b0; `bus_addr_o`, `bus_wdata_o` and `ram_data_o` = 32'h0; `stallreq_o` = 0 (state IDLE, `ram_ce_i` treated per IDLE rule); counter = 0.
- **Reset mid-operation:** asserting `rst` in BUSY forces IDLE and `bus_req_o` = 0 immediately, without waiting for a clock edge. A late ack is then ignored.
- **Latency:** with `ram_ce_i` seen in cycle 0, `bus_req_o` rises at cycle 1. If ack arrives in cycle k ≥ 1, DONE occurs in cycle k+1. `stallreq_o` is high in cycles 0..k, so the minimum access is 3 cycles with 2 stalled.
- **Timeout:** with no ack, DONE occurs in cycle `TIMEOUT_CYCLES`+1.
- **Back-to-back:** the second access begins stalling in the IDLE cycle right after DONE; there are no dead cycles beyond that IDLE.
- The pipeline controller must let the MEM stage advance in every cycle where `stallreq_o` = 0, so DONE lasts exactly one cycle.

## Test plan
- **Reset:** reset → all outputs at reset values. Assert `rst` during BUSY → `bus_req_o` falls before the next edge and the state is IDLE.
- **Read, ack in cycle 1:** `ram_ce_i`=1, `ram_we_i`=0, `ram_addr_i`=32'h0000_1006, `ram_sel_i`=4'b0011. Ack at cycle 1 with `bus_rdata_i`=32'hDEAD_BEEF → `bus_addr_o`=32'h0000_1004, `stallreq_o` high in cycles 0-1, `ram_data_o`=32'hDEAD_BEEF only in cycle 2.
- **Write with 5-cycle ack delay, inputs toggled mid-BUSY:** write 32'h1234_5678 to 32'h20, sel 4'b1111 → bus outputs hold the latched values until ack, `ram_data_o`=0 in DONE, 6 stalled cycles.
- **Timeout:** `TIMEOUT_CYCLES`=4, never ack → DONE at cycle 5, `ram_data_o`=0, `err_o`=1 and stays 1 through later successful accesses until `rst`.
- **Ack-versus-timeout tie, plus spurious ack:** ack on the cycle the counter reaches 4 → data captured, `err_o`=0. Ack pulse while IDLE → no state change.
- **Back-to-back reads:** two reads with `ram_ce_i` held high → two DONE cycles separated by exactly one IDLE cycle, each returning its own data.

Source files
------------

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns the core's single-cycle data-RAM port into a
// request/acknowledge bus transaction, stalling the MEM stage until the
// bus answers (or times out) and presenting the read word for one cycle.
module data_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ce_i,
   input  logic        ram_we_i,
   input  logic [3:0]  ram_sel_i,
   input  logic [31:0] ram_addr_i,
   input  logic [31:0] ram_data_i,
   output logic [31:0] ram_data_o,
   output logic        stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [9:0] TIMEOUT = 10'(TIMEOUT_CYCLES);

   state_t      state, state_next;
   logic [9:0]  cnt;
   logic [9:0]  cnt_inc;
   logic [31:0] rdata;
   logic        start, ack_done, tmo_done;

   assign cnt_inc = cnt + 10'd1;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state, stall request and completion strobes; ack wins over timeout
   always_comb begin
      state_next = state;
      start      = 1'b0;
      ack_done   = 1'b0;
      tmo_done   = 1'b0;
      stallreq_o = 1'b0;
      ram_data_o = '0;
      case (state)
         IDLE: begin
            if (ram_ce_i) begin
               stallreq_o = 1'b1;
               start      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            stallreq_o = 1'b1;
            if (bus_ack_i) begin
               ack_done   = 1'b1;
               state_next = DONE;
            end else if (cnt_inc == TIMEOUT) begin
               tmo_done   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            ram_data_o = rdata;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus latches, timeout counter, read register and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_sel_o   <= '0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         cnt         <= '0;
         rdata       <= '0;
         err_o       <= 1'b0;
      end else begin
         if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= ram_we_i;
            bus_sel_o   <= ram_sel_i;
            bus_addr_o  <= ram_addr_i & 32'hFFFF_FFFC;
            bus_wdata_o <= ram_data_i;
            cnt         <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt_inc;
         end
         if (ack_done) begin
            rdata     <= bus_we_o ? '0 : bus_rdata_i;
            bus_req_o <= 1'b0;
         end
         if (tmo_done) begin
            rdata     <= '0;
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge. Instance a uses the default timeout,
// instance b uses a 4-cycle timeout; they share all inputs except ce and ack.
module tb_data_bus_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_a = 1'b0, ce_b = 1'b0;
   logic        ack_a = 1'b0, ack_b = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] addr = '0, wdata = '0, rdata = '0;

   logic [31:0] rdo_a, baddr_a, bwd_a, rdo_b, baddr_b, bwd_b;
   logic        stall_a, req_a, bwe_a, err_a, stall_b, req_b, bwe_b, err_b;
   logic [3:0]  bsel_a, bsel_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_bus_bridge dut_a (
      .clk(clk), .rst(rst), .ram_ce_i(ce_a), .ram_we_i(we), .ram_sel_i(sel),
      .ram_addr_i(addr), .ram_data_i(wdata), .ram_data_o(rdo_a),
      .stallreq_o(stall_a), .bus_req_o(req_a), .bus_we_o(bwe_a),
      .bus_sel_o(bsel_a), .bus_addr_o(baddr_a), .bus_wdata_o(bwd_a),
      .bus_ack_i(ack_a), .bus_rdata_i(rdata), .err_o(err_a)
   );

   data_bus_bridge #(.TIMEOUT_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .ram_ce_i(ce_b), .ram_we_i(we), .ram_sel_i(sel),
      .ram_addr_i(addr), .ram_data_i(wdata), .ram_data_o(rdo_b),
      .stallreq_o(stall_b), .bus_req_o(req_b), .bus_we_o(bwe_b),
      .bus_sel_o(bsel_b), .bus_addr_o(baddr_b), .bus_wdata_o(bwd_b),
      .bus_ack_i(ack_b), .bus_rdata_i(rdata), .err_o(err_b)
   );

   // Advance to just after the next rising edge (start of a new cycle)
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({rdo_a, baddr_a, bwd_a, bsel_a, stall_a, req_a, bwe_a, err_a} !== '0) begin
         errors++;
         $display("FAIL reset_a: got rdo=%h addr=%h wd=%h sel=%h st=%b req=%b we=%b err=%b required all 0",
                  rdo_a, baddr_a, bwd_a, bsel_a, stall_a, req_a, bwe_a, err_a);
      end
      checks++;
      if ({rdo_b, baddr_b, bwd_b, bsel_b, stall_b, req_b, bwe_b, err_b} !== '0) begin
         errors++;
         $display("FAIL reset_b: got rdo=%h addr=%h st=%b req=%b err=%b required all 0",
                  rdo_b, baddr_b, stall_b, req_b, err_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_read();
      tick();
      ce_a = 1'b1; we = 1'b0; addr = 32'h0000_1006; sel = 4'b0011;
      @(negedge clk);
      checks++;
      if (stall_a !== 1'b1 || req_a !== 1'b0) begin
         errors++;
         $display("FAIL read_c0: got stall=%b req=%b required 1 0", stall_a, req_a);
      end
      tick();
      ack_a = 1'b1; rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (stall_a !== 1'b1 || req_a !== 1'b1 || baddr_a !== 32'h0000_1004 ||
          bsel_a !== 4'b0011 || bwe_a !== 1'b0 || rdo_a !== 32'h0) begin
         errors++;
         $display("FAIL read_c1: got stall=%b req=%b addr=%h sel=%b we=%b rdo=%h required 1 1 00001004 0011 0 0",
                  stall_a, req_a, baddr_a, bsel_a, bwe_a, rdo_a);
      end
      tick();
      ack_a = 1'b0; ce_a = 1'b0; rdata = '0;
      @(negedge clk);
      checks++;
      if (stall_a !== 1'b0 || req_a !== 1'b0 || rdo_a !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read_c2: got stall=%b req=%b rdo=%h required 0 0 deadbeef", stall_a, req_a, rdo_a);
      end
      tick();
      @(negedge clk);
      checks++;
      if (stall_a !== 1'b0 || rdo_a !== 32'h0) begin
         errors++;
         $display("FAIL read_c3: got stall=%b rdo=%h required 0 0", stall_a, rdo_a);
      end
   endtask

   task automatic test_write();
      int stalls = 0;
      tick();
      ce_a = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'b1111; wdata = 32'h1234_5678;
      @(negedge clk);
      if (stall_a === 1'b1) stalls++;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 2) begin
            ce_a = 1'b0; we = 1'b0; sel = 4'b0000; addr = 32'hFFFF_FFFF; wdata = '0;
         end
         ack_a = (c == 5);
         rdata = (c == 5) ? 32'hAAAA_5555 : 32'h0;
         @(negedge clk);
         if (stall_a === 1'b1) stalls++;
         checks++;
         if (c <= 5) begin
            if (req_a !== 1'b1 || bwe_a !== 1'b1 || bsel_a !== 4'b1111 ||
                baddr_a !== 32'h20 || bwd_a !== 32'h1234_5678 || rdo_a !== 32'h0) begin
               errors++;
               $display("FAIL write_busy c%0d: got req=%b we=%b sel=%b addr=%h wd=%h rdo=%h required 1 1 1111 00000020 12345678 0",
                        c, req_a, bwe_a, bsel_a, baddr_a, bwd_a, rdo_a);
            end
         end else begin
            if (req_a !== 1'b0 || stall_a !== 1'b0 || rdo_a !== 32'h0) begin
               errors++;
               $display("FAIL write_done: got req=%b stall=%b rdo=%h required 0 0 0", req_a, stall_a, rdo_a);
            end
         end
      end
      ack_a = 1'b0;
      checks++;
      if (stalls != 6) begin
         errors++;
         $display("FAIL write_stalls: got %0d required 6", stalls);
      end
   endtask

   task automatic test_reset_busy();
      tick();
      ce_a = 1'b1; we = 1'b0; addr = 32'h300; sel = 4'b1111;
      @(negedge clk);
      tick();
      ce_a = 1'b0;
      @(negedge clk);
      checks++;
      if (req_a !== 1'b1) begin
         errors++;
         $display("FAIL rstbusy_pre: got req=%b required 1", req_a);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (req_a !== 1'b0 || stall_a !== 1'b0 || baddr_a !== 32'h0) begin
         errors++;
         $display("FAIL rstbusy_async: got req=%b stall=%b addr=%h required 0 0 0", req_a, stall_a, baddr_a);
      end
      #2;
      rst = 1'b0; ack_a = 1'b1; rdata = 32'h7777_7777;
      tick();
      ack_a = 1'b0; rdata = '0;
      @(negedge clk);
      checks++;
      if (stall_a !== 1'b0 || req_a !== 1'b0 || rdo_a !== 32'h0) begin
         errors++;
         $display("FAIL rstbusy_lateack: got stall=%b req=%b rdo=%h required 0 0 0", stall_a, req_a, rdo_a);
      end
   endtask

   task automatic test_tie_spurious();
      tick();
      ce_b = 1'b1; we = 1'b0; addr = 32'h80; sel = 4'b1111;
      @(negedge clk);
      for (int c = 1; c <= 7; c++) begin
         tick();
         ce_b  = 1'b0;
         ack_b = (c == 4) || (c == 6);
         rdata = (c == 4) ? 32'h5A5A_A5A5 : ((c == 6) ? 32'hFFFF_0000 : 32'h0);
         @(negedge clk);
         if (c == 4) begin
            checks++;
            if (stall_b !== 1'b1 || req_b !== 1'b1) begin
               errors++;
               $display("FAIL tie_busy: got stall=%b req=%b required 1 1", stall_b, req_b);
            end
         end else if (c == 5) begin
            checks++;
            if (rdo_b !== 32'h5A5A_A5A5 || err_b !== 1'b0 || stall_b !== 1'b0) begin
               errors++;
               $display("FAIL tie_done: got rdo=%h err=%b stall=%b required 5a5aa5a5 0 0", rdo_b, err_b, stall_b);
            end
         end else if (c >= 6) begin
            checks++;
            if (stall_b !== 1'b0 || req_b !== 1'b0 || rdo_b !== 32'h0 || err_b !== 1'b0) begin
               errors++;
               $display("FAIL spurious c%0d: got stall=%b req=%b rdo=%h err=%b required 0 0 0 0",
                        c, stall_b, req_b, rdo_b, err_b);
            end
         end
      end
      ack_b = 1'b0;
   endtask

   task automatic test_timeout();
      tick();
      ce_b = 1'b1; we = 1'b0; addr = 32'h40; sel = 4'b1111; rdata = 32'hCAFE_F00D;
      @(negedge clk);
      for (int c = 1; c <= 6; c++) begin
         tick();
         ce_b = 1'b0;
         @(negedge clk);
         checks++;
         if (c <= 4) begin
            if (stall_b !== 1'b1 || req_b !== 1'b1 || err_b !== 1'b0) begin
               errors++;
               $display("FAIL timeout_busy c%0d: got stall=%b req=%b err=%b required 1 1 0", c, stall_b, req_b, err_b);
            end
         end else begin
            if (stall_b !== 1'b0 || req_b !== 1'b0 || rdo_b !== 32'h0 || err_b !== 1'b1) begin
               errors++;
               $display("FAIL timeout_end c%0d: got stall=%b req=%b rdo=%h err=%b required 0 0 0 1",
                        c, stall_b, req_b, rdo_b, err_b);
            end
         end
      end
      rdata = '0;
      // A later successful access must leave the error flag set
      tick();
      ce_b = 1'b1; addr = 32'h44;
      @(negedge clk);
      tick();
      ce_b = 1'b0; ack_b = 1'b1; rdata = 32'h0BAD_F00D;
      @(negedge clk);
      tick();
      ack_b = 1'b0; rdata = '0;
      @(negedge clk);
      checks++;
      if (rdo_b !== 32'h0BAD_F00D || err_b !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got rdo=%h err=%b required 0badf00d 1", rdo_b, err_b);
      end
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (err_b !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got err=%b required 0", err_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_rdo [0:6];
      logic        exp_st  [0:6];
      exp_rdo = '{32'h0, 32'h0, 32'h1111_1111, 32'h0, 32'h0, 32'h2222_2222, 32'h0};
      exp_st  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tick();
      ce_a = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'b1111;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) tick();
         ack_a = (c == 1) || (c == 4);
         rdata = (c == 1) ? 32'h1111_1111 : ((c == 4) ? 32'h2222_2222 : 32'h0);
         if (c == 2) addr = 32'h200;
         if (c == 5) ce_a = 1'b0;
         @(negedge clk);
         checks++;
         if (stall_a !== exp_st[c] || rdo_a !== exp_rdo[c]) begin
            errors++;
            $display("FAIL b2b c%0d: got stall=%b rdo=%h required %b %h", c, stall_a, rdo_a, exp_st[c], exp_rdo[c]);
         end
         if (c == 4) begin
            checks++;
            if (baddr_a !== 32'h200) begin
               errors++;
               $display("FAIL b2b_addr: got %h required 00000200", baddr_a);
            end
         end
      end
      ack_a = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_reset_busy();
      test_tie_spurious();
      test_timeout();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
